// File: rtl/systolic_pkg.sv
// Shared types for the systolic array result path.
// acc_t matches the array accumulator width.
// row_t carries one realigned result row of C together with its end-of-matrix tag.
package systolic_pkg;

  localparam int N         = 2;
  localparam int ACC_WIDTH = 32;
  localparam int PE_LAT    = 2;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    acc_t [N-1:0] data;
    logic         last;
  } row_t;

endpackage

// File: rtl/systolic_result_collector_if.sv
// Result-row stream leaving the collector: valid/ready handshake plus row payload.
// master = the collector (producer), slave = the downstream consumer.
interface systolic_result_collector_if;
  import systolic_pkg::*;

  logic row_valid;
  logic row_ready;
  acc_t row_data [N];
  logic row_last;

  modport master (
    output row_valid,
    output row_data,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_last,
    output row_ready
  );

endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO of result rows with an occupancy count.
// The head output keeps showing the last popped row once the FIFO runs empty.
// After reset, that held value is all zeros.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module result_fifo
  import systolic_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  row_t             push_row,
  input  logic             pop,
  output row_t             head_row,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  row_t             mem_q [DEPTH];
  row_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  row_t             last_q, last_d;
  logic             do_push, do_pop;

  // Next-state: a pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_row;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and held-head register.
  // All of these clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Head view: the live entry while non-empty, otherwise the last row handed out.
  always_comb begin
    head_valid = (count_q != '0);
    head_row   = head_valid ? mem_q[rd_ptr_q] : last_q;
    count      = count_q;
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Output-side collector for the NxN systolic array.
// It realigns the column-skewed c_out values into whole rows of C.
// Rows are queued in a small FIFO and offered on a valid/ready stream.
// Admission credits (a_ready) are issued so that every row in flight already owns a FIFO slot.
module systolic_result_collector #(
  parameter int N         = systolic_pkg::N,
  parameter int ACC_WIDTH = systolic_pkg::ACC_WIDTH,
  parameter int PE_LAT    = systolic_pkg::PE_LAT,
  parameter int M_ROWS    = 2,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        a_issue,
  output logic                        a_ready,
  input  logic signed [ACC_WIDTH-1:0] c_in [N],
  systolic_result_collector_if.master rows,
  output logic                        overflow
);
  import systolic_pkg::*;

  localparam int TOK_LEN = PE_LAT + N - 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int RC_W    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;

  typedef logic signed [ACC_WIDTH-1:0] col_t;

  logic [TOK_LEN-1:0] tok_q, tok_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [RC_W-1:0]    row_cnt_q, row_cnt_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               push;
  logic               row_is_last;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   credits_used;
  col_t               aligned [N];
  row_t               push_row;
  row_t               head_row;
  logic               head_valid;
  logic               pop;

  // Credits: every accepted row and every queued row holds one FIFO slot.
  // Admission continues while a slot remains.
  always_comb begin
    credits_used = {1'b0, fifo_count} + {1'b0, in_flight_q};
    a_ready      = credits_used < SUM_W'(DEPTH);
    accept       = a_issue && enable && a_ready;
    push         = enable && tok_q[TOK_LEN-1];
  end

  // Token pipe: a token at stage PE_LAT+j-1 means c_in[j] holds that row's column j.
  // The last stage is column N-1, which completes the row.
  always_comb begin
    tok_d = tok_q;
    if (enable) begin
      tok_d[0] = accept;
      for (int k = 1; k < TOK_LEN; k++) begin
        tok_d[k] = tok_q[k-1];
      end
    end
  end

  // Rows in flight: counts up on admission and down when the row lands in the FIFO.
  // A protocol violation is latched for good.
  always_comb begin
    in_flight_d = in_flight_q;
    case ({accept, push})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    overflow_d = overflow_q || (a_issue && !a_ready);
  end

  // Row counter: tags the final row of each matrix, then wraps to row 0.
  always_comb begin
    row_is_last = (row_cnt_q == RC_W'(M_ROWS - 1));
    row_cnt_d   = row_cnt_q;
    if (push) begin
      row_cnt_d = row_is_last ? '0 : row_cnt_q + RC_W'(1);
    end
  end

  // Control state registers.
  // A reset throws away every token, so no partially collected row can be pushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok_q       <= '0;
      in_flight_q <= '0;
      row_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tok_q       <= tok_d;
      in_flight_q <= in_flight_d;
      row_cnt_q   <= row_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // De-skew: column j waits N-1-j enabled cycles so that it lines up with column N-1.
  for (genvar j = 0; j < N - 1; j++) begin : g_dly
    localparam int STAGES = N - 1 - j;
    col_t dly_q [STAGES];
    col_t dly_d [STAGES];

    // Shift this column one stage each time the array advances.
    always_comb begin
      dly_d = dly_q;
      if (enable) begin
        dly_d[0] = c_in[j];
        for (int s = 1; s < STAGES; s++) begin
          dly_d[s] = dly_q[s-1];
        end
      end
    end

    // Delay line storage, cleared on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES; s++) begin
          dly_q[s] <= '0;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign aligned[j] = dly_q[STAGES-1];
  end

  assign aligned[N-1] = c_in[N-1];

  // Assemble the aligned row with its end-of-matrix tag for the FIFO.
  always_comb begin
    push_row = '0;
    for (int j = 0; j < N; j++) begin
      push_row.data[j] = aligned[j];
    end
    push_row.last = row_is_last;
  end

  assign pop = head_valid && rows.row_ready;

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_row   (push_row),
    .pop        (pop),
    .head_row   (head_row),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Drive the output stream from the FIFO head.
  always_comb begin
    rows.row_valid = head_valid;
    rows.row_last  = head_row.last;
    for (int j = 0; j < N; j++) begin
      rows.row_data[j] = head_row.data[j];
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector.
// A small array model drives c_in with the rows of C = A*B, where B=[5 6;7 8].
// Each C row appears one column per enabled cycle, following the PE_LAT skew.
module tb_systolic_result_collector;
  import systolic_pkg::*;

  localparam int M_ROWS  = 2;
  localparam int DEPTH   = 4;
  localparam int TOK_LEN = PE_LAT + N - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic a_issue;
  logic a_ready;
  logic overflow;
  acc_t c_in [N];
  int   cur_idx;
  int   stg_idx [TOK_LEN];
  int   checks = 0;
  int   errors = 0;
  int   popped;
  int   seen;

  // C rows for A rows [1 2],[3 4],[5 6],[7 8] against B=[5 6;7 8], hand-computed
  int ctab [4][N] = '{'{19, 22}, '{43, 50}, '{67, 78}, '{91, 106}};

  systolic_result_collector_if rif ();

  systolic_result_collector #(
    .N         (N),
    .ACC_WIDTH (ACC_WIDTH),
    .PE_LAT    (PE_LAT),
    .M_ROWS    (M_ROWS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .a_issue  (a_issue),
    .a_ready  (a_ready),
    .c_in     (c_in),
    .rows     (rif),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Array model: the issued row index travels with enable.
  // Column j is presented PE_LAT+j cycles after issue.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TOK_LEN; k++) stg_idx[k] <= -1;
    end else if (enable) begin
      stg_idx[0] <= a_issue ? cur_idx : -1;
      for (int k = 1; k < TOK_LEN; k++) stg_idx[k] <= stg_idx[k-1];
    end
  end

  // Array output: real results where a row is present, recognisable junk elsewhere.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      if (stg_idx[PE_LAT+j-1] >= 0) c_in[j] = acc_t'(ctab[stg_idx[PE_LAT+j-1]][j]);
      else c_in[j] = acc_t'(-777 - j);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic issue, input int idx, input logic en, input logic rdy);
    a_issue       = issue;
    cur_idx       = idx;
    enable        = en;
    rif.row_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkRow(input string tag, input int d0, input int d1, input logic last);
    checkOutput({tag, "_valid"}, rif.row_valid, 1);
    checkOutput({tag, "_d0"}, rif.row_data[0], d0);
    checkOutput({tag, "_d1"}, rif.row_data[1], d1);
    checkOutput({tag, "_last"}, rif.row_last, last);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, -1, 1, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, -1, 1, 0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_valid", rif.row_valid, 0);
    checkOutput("rst_d0", rif.row_data[0], 0);
    checkOutput("rst_d1", rif.row_data[1], 0);
    checkOutput("rst_last", rif.row_last, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_a_ready", a_ready, 1);
    rst_n = 1'b1;

    $display("[TB] basic 2x2");
    applyStimulus(1, 0, 1, 1); tick();
    applyStimulus(1, 1, 1, 1); tick();
    applyStimulus(0, -1, 1, 1);
    checkOutput("basic_t2_valid", rif.row_valid, 0); tick();
    checkOutput("basic_t3_valid", rif.row_valid, 0); tick();
    checkRow("basic_r0", 19, 22, 0); tick();
    checkRow("basic_r1", 43, 50, 1); tick();
    checkOutput("basic_empty_valid", rif.row_valid, 0);
    checkOutput("basic_hold_d0", rif.row_data[0], 43);
    checkOutput("basic_hold_d1", rif.row_data[1], 50);

    $display("[TB] backpressure");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i, 1, 0);
      checkOutput($sformatf("bp_ready_issue%0d", i), a_ready, 1);
      tick();
    end
    applyStimulus(0, -1, 1, 0);
    checkOutput("bp_ready_low", a_ready, 0);
    repeat (6) tick();
    checkOutput("bp_ready_still_low", a_ready, 0);
    checkOutput("bp_overflow", overflow, 0);
    applyStimulus(0, -1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      checkRow($sformatf("bp_r%0d", i), ctab[i][0], ctab[i][1], logic'(i % 2));
      if (i == 1) checkOutput("bp_credit_back", a_ready, 1);
      tick();
    end
    checkOutput("bp_drained", rif.row_valid, 0);

    $display("[TB] stall");
    doReset();
    applyStimulus(1, 0, 1, 1); tick();
    applyStimulus(1, 1, 1, 1); tick();
    applyStimulus(0, -1, 1, 1);
    checkOutput("st_t2_valid", rif.row_valid, 0); tick();
    checkOutput("st_t3_valid", rif.row_valid, 0); tick();
    applyStimulus(0, -1, 0, 1);
    checkRow("st_r0", 19, 22, 0); tick();
    checkOutput("st_t5_valid", rif.row_valid, 0); tick();
    checkOutput("st_t6_valid", rif.row_valid, 0); tick();
    applyStimulus(0, -1, 1, 1);
    checkOutput("st_t7_valid", rif.row_valid, 0); tick();
    checkRow("st_r1", 43, 50, 1); tick();
    checkOutput("st_t9_valid", rif.row_valid, 0);

    $display("[TB] overflow");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i, 1, 0);
      tick();
    end
    applyStimulus(1, 0, 1, 0);
    checkOutput("ovf_ready_low", a_ready, 0);
    tick();
    applyStimulus(0, -1, 1, 0);
    checkOutput("ovf_set", overflow, 1);
    repeat (8) tick();
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(0, -1, 1, 1);
    popped = 0;
    for (int i = 0; i < 12; i++) begin
      if (rif.row_valid) popped++;
      tick();
    end
    checkOutput("ovf_rows", popped, 4);
    checkOutput("ovf_sticky_after", overflow, 1);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 2, 1, 1); tick();
    applyStimulus(0, -1, 1, 1);
    repeat (5) tick();
    applyStimulus(1, 0, 1, 1); tick();
    applyStimulus(1, 1, 1, 1); tick();
    applyStimulus(0, -1, 1, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_valid", rif.row_valid, 0);
    checkOutput("mid_d0", rif.row_data[0], 0);
    checkOutput("mid_d1", rif.row_data[1], 0);
    checkOutput("mid_last", rif.row_last, 0);
    checkOutput("mid_overflow", overflow, 0);
    checkOutput("mid_a_ready", a_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rif.row_valid) seen++;
      tick();
    end
    checkOutput("mid_no_rows", seen, 0);
    applyStimulus(1, 0, 1, 1); tick();
    applyStimulus(1, 1, 1, 1); tick();
    applyStimulus(0, -1, 1, 1);
    tick();
    tick();
    checkRow("mid_r0", 19, 22, 0); tick();
    checkRow("mid_r1", 43, 50, 1); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
